// File: rtl/euclid_dist_core.sv
// euclid_dist_core: streams coordinate pairs, accumulates squared differences and
// optionally takes the bit-serial integer square root (define EUCLID_SQRT_EN).
module euclid_dist_core #(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned DIM_MAX = 8,
  localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(DIM_MAX),
  localparam int unsigned DIM_W   = $clog2(DIM_MAX) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              busy,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  input  logic              res_ack
);

  localparam int unsigned SQ_W = 2 * DATA_W;

`ifdef EUCLID_SQRT_EN
  localparam int unsigned RT_W  = (ACC_W + 1) / 2;
  localparam int unsigned X_W   = 2 * RT_W;
  localparam int unsigned REM_W = RT_W + 1;
  localparam int unsigned TRY_W = RT_W + 3;
  localparam int unsigned SC_W  = $clog2(RT_W);

  typedef enum logic [1:0] {IDLE, ACCUM, SQRT, DONE} state_t;
  localparam state_t POST_ACC = SQRT;
`else
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam state_t POST_ACC = DONE;
`endif

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [DIM_W-1:0]  cnt, cnt_nxt;
  logic [DIM_W-1:0]  dim_q, dim_nxt, dim_clamp;
  logic              in_ready_nxt, busy_nxt, res_valid_nxt;
  logic [ACC_W-1:0]  res_nxt, result_c;

  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]      mag;
  logic [SQ_W-1:0]        sq;

`ifdef EUCLID_SQRT_EN
  logic [X_W-1:0]    sq_x, sq_x_nxt;
  logic [RT_W-1:0]   root, root_nxt;
  logic [REM_W-1:0]  rem, rem_nxt;
  logic [SC_W-1:0]   sq_cnt, sq_cnt_nxt;
  logic [TRY_W-1:0]  rem_sh, trial;
`endif

  // Squared difference of the current pair; |d| always fits in DATA_W bits unsigned.
  always_comb begin
    diff      = $signed({in_a[DATA_W-1], in_a}) - $signed({in_b[DATA_W-1], in_b});
    mag       = diff[DATA_W] ? DATA_W'(-diff) : DATA_W'(diff);
    sq        = SQ_W'(mag) * SQ_W'(mag);
    dim_clamp = (dim > DIM_W'(DIM_MAX)) ? DIM_W'(DIM_MAX) : dim;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    dim_nxt       = dim_q;
    result_c      = '0;
    res_nxt       = '0;
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    res_valid_nxt = 1'b0;
`ifdef EUCLID_SQRT_EN
    sq_x_nxt   = sq_x;
    root_nxt   = root;
    rem_nxt    = rem;
    sq_cnt_nxt = sq_cnt;
    rem_sh     = {rem, sq_x[X_W-1 -: 2]};
    trial      = TRY_W'({root, 2'b01});
`endif

    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          dim_nxt   = dim_clamp;
          state_nxt = (dim_clamp == '0) ? POST_ACC : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = acc + ACC_W'(sq);
          cnt_nxt = cnt + DIM_W'(1);
          if (cnt_nxt == dim_q) state_nxt = POST_ACC;
        end
      end
`ifdef EUCLID_SQRT_EN
      SQRT: begin
        // Restoring digit step: bring down two operand bits, try appending a 1.
        if (rem_sh >= trial) begin
          rem_nxt  = REM_W'(rem_sh - trial);
          root_nxt = {root[RT_W-2:0], 1'b1};
        end else begin
          rem_nxt  = REM_W'(rem_sh);
          root_nxt = {root[RT_W-2:0], 1'b0};
        end
        sq_x_nxt   = {sq_x[X_W-3:0], 2'b00};
        sq_cnt_nxt = sq_cnt + SC_W'(1);
        if (sq_cnt == SC_W'(RT_W - 1)) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (res_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

`ifdef EUCLID_SQRT_EN
    if (state_nxt == SQRT && state != SQRT) begin
      sq_x_nxt   = X_W'(acc_nxt);
      root_nxt   = '0;
      rem_nxt    = '0;
      sq_cnt_nxt = '0;
    end
    result_c = ACC_W'(root_nxt);
`else
    result_c = acc_nxt;
`endif

    in_ready_nxt  = (state_nxt == ACCUM);
    busy_nxt      = (state_nxt != IDLE);
    res_valid_nxt = (state_nxt == DONE);
    // Result is captured on entry to DONE, held there, and cleared otherwise.
    if (state_nxt == DONE) res_nxt = (state == DONE) ? res_data : result_c;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      dim_q     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      dim_q     <= dim_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_nxt;
    end
  end

`ifdef EUCLID_SQRT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sq_x   <= '0;
      root   <= '0;
      rem    <= '0;
      sq_cnt <= '0;
    end else begin
      sq_x   <= sq_x_nxt;
      root   <= root_nxt;
      rem    <= rem_nxt;
      sq_cnt <= sq_cnt_nxt;
    end
  end
`endif

endmodule

// File: doc/euclid_dist_core.md
# euclid_dist_core

- Sequential Euclidean-distance engine behind the DistanciaEuclidianaV3 AXI4-Lite register interface.
- The register file issues a start command, then streams coordinate pairs (a_i, b_i) one per handshake.
- The core accumulates the sum of squared differences and optionally takes its integer square root.
- It presents the result with a valid/ack handshake for the register file to latch into a readable register.

## Interface
- DATA_W, 16, width of each signed coordinate.
- DIM_MAX, 8, maximum number of dimensions per computation.
- ACC_W (derived, not overridable), 2*DATA_W + $clog2(DIM_MAX), accumulator and result width (35 by default).
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle command; honoured only in IDLE.
- dim  in  $clog2(DIM_MAX)+1  number of pairs; sampled with start.
- in_valid  in  1  coordinate pair present.
- in_ready  out  1  core accepts a pair this cycle.
- in_a, in_b  in  DATA_W each  signed two's-complement coordinates.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result available; held until acked.
- res_data  out  ACC_W  result, zero-extended.
- res_ack  in  1  consumer takes the result.

## Operation
- States: IDLE, ACCUM, SQRT, DONE.
- IDLE:
  - start=1 clears acc, clears the pair counter and latches dim.
  - If dim>DIM_MAX, it is clamped to DIM_MAX.
  - dim=0 goes straight to SQRT (or to DONE when sqrt is compiled out) with acc=0.
  - Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: d = in_a - in_b computed at DATA_W+1 bits signed, acc += d*d with the square taken unsigned at 2*DATA_W bits, counter increments.
  - No overflow is possible at the given widths.
  - When the pair that brings the counter to dim is accepted, go to SQRT (or DONE).
- SQRT:
  - Bit-serial restoring integer square root of acc, producing one result bit per cycle.
  - Runs for (ACC_W+1)/2 cycles (18 by default).
  - Result is floor(sqrt(acc)), width (ACC_W+1)/2.
  - Then go to DONE.
- DONE:
  - res_valid=1 and res_data is stable.
  - On res_ack go to IDLE on the next edge.
- start outside IDLE is ignored.
- res_ack outside DONE is ignored.
- in_valid outside ACCUM is ignored; no pair is consumed.

## Timing
- Reset values: in_ready=0, busy=0, res_valid=0, res_data=0; state=IDLE; acc and counter are 0.
- Reset asserted in any state aborts immediately: outputs go to reset values asynchronously and the partial result is discarded.
- start sampled at edge 0; ACCUM is active from cycle 1.
- With in_valid held high, pairs are accepted on cycles 1..dim at one per cycle, with zero bubbles.
- In SQRT: cycles dim+1..dim+18.
- res_valid rises at cycle dim+19 (sqrt enabled) or dim+1 (sqrt disabled).
- res_ack sampled high in the first DONE cycle gives res_valid=1 for exactly one cycle; busy falls on the same edge.
- start is accepted one cycle after leaving DONE, never in the same cycle as res_ack.
- in_ready falls on the edge that accepts the last pair.
- busy rises on the edge that samples start.

## Configuration
- EUCLID_SQRT_EN defined:
  - SQRT state and root datapath are present.
  - res_data = floor(sqrt(sum of squares)), zero-extended to ACC_W.
- EUCLID_SQRT_EN undefined:
  - SQRT state is omitted; ACCUM goes directly to DONE.
  - res_data = raw sum of squares (squared distance).
  - Root logic is not synthesised.

## Test plan
- dim=2, pairs (3,0),(4,0), in_valid continuous:
  - res_data=5 with res_valid at cycle 21 (EUCLID_SQRT_EN).
  - res_data=25 with res_valid at cycle 3 (undefined).
- dim=1, a=-32768, b=32767:
  - d*d=4294836225 (sqrt off), res_data=65535 (sqrt on).
- dim=8, every pair a=32767, b=-32768:
  - acc=34358689800 with no wrap (sqrt off), res_data=185360 (sqrt on).
- dim=3, in_valid toggled every other cycle, res_ack withheld 10 cycles:
  - only handshaked pairs are counted.
  - res_valid and res_data hold steady for all 10 cycles.
  - IDLE one cycle after res_ack.
- dim=0:
  - res_data=0; in_ready never asserts.
  - A start pulse while busy has no effect; the running result is unchanged.
- ARESETN pulled low after 2 of 4 pairs:
  - all outputs go to 0 at once.
  - A fresh dim=1, (1,-1) run after release gives 2 (sqrt on) or 4 (sqrt off).
